// File: rtl/miriscv_mem_pkg.sv
// miriscv_mem_pkg: shared constants and byte-lane merge helper for the miriscv data memory
package miriscv_mem_pkg;
  localparam int BE_W = 4;
  localparam logic [31:0] MMIO_BASE = 32'h8000_0000;
  localparam logic [3:0] MMIO_CYCLE_LO = 4'h0;
  localparam logic [3:0] MMIO_CYCLE_HI = 4'h4;
  localparam logic [3:0] MMIO_TOHOST = 4'h8;
  localparam logic [3:0] MMIO_SCRATCH = 4'hC;
  localparam logic [31:0] FAULT_WORD = 32'hDEAD_BEEF;
  function automatic logic [31:0] be_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                           input logic [BE_W-1:0] be);
    logic [31:0] r;
    for (int k = 0; k < BE_W; k++) r[8*k +: 8] = be[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
    return r;
  endfunction
endpackage

// File: rtl/miriscv_dmem_mmio.sv
// miriscv_dmem_mmio: cycle counter, CYCLE_HI shadow, TOHOST and SCRATCH with registered reads
// Ports: clk_i/rst_i (sync, active-high); req_i (window hit), we_i, be_i, off_i (word offset),
// wdata_i; rdata_o (registered read data), halt_o (sticky nonzero TOHOST), tohost_o.
module miriscv_dmem_mmio
  import miriscv_mem_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  input  logic            we_i,
  input  logic [BE_W-1:0] be_i,
  input  logic [1:0]      off_i,
  input  logic [31:0]     wdata_i,
  output logic [31:0]     rdata_o,
  output logic            halt_o,
  output logic [31:0]     tohost_o
);
  logic [63:0] cycle_q;
  logic [31:0] shadow_q, tohost_q, scratch_q, rdata_q, tohost_d, scratch_d, rd_d;
  logic        halt_q, wr_tohost, wr_scratch;
  logic [3:0]  off;
  always_comb begin
    off = {off_i, 2'b00};
    wr_tohost = req_i && we_i && off == MMIO_TOHOST;
    wr_scratch = req_i && we_i && off == MMIO_SCRATCH;
    tohost_d = be_merge(tohost_q, wdata_i, be_i);
    scratch_d = be_merge(scratch_q, wdata_i, be_i);
    rd_d = off == MMIO_CYCLE_LO ? cycle_q[31:0] :
           off == MMIO_CYCLE_HI ? shadow_q :
           off == MMIO_TOHOST   ? tohost_q : scratch_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_q <= '0;
      shadow_q <= '0;
      tohost_q <= '0;
      scratch_q <= '0;
      rdata_q <= '0;
      halt_q <= 1'b0;
    end else begin
      cycle_q <= cycle_q + 64'd1;
      if (wr_tohost) tohost_q <= tohost_d;
      if (wr_scratch) scratch_q <= scratch_d;
      halt_q <= halt_q | (wr_tohost && tohost_d != '0);
      if (req_i && !we_i) rdata_q <= rd_d;
      // a CYCLE_LO read freezes the upper half so a following CYCLE_HI read is coherent
      if (req_i && !we_i && off == MMIO_CYCLE_LO) shadow_q <= cycle_q[63:32];
    end
  end
  assign rdata_o = rdata_q;
  assign halt_o = halt_q;
  assign tohost_o = tohost_q;
endmodule

// File: rtl/miriscv_data_mem.sv
// miriscv_data_mem: single-port byte-enable data RAM with fault tracking and optional MMIO window
// Ports: clk_i/rst_i (sync, active-high); data_req_i, data_we_i, data_be_i, data_addr_i,
// data_wdata_i (LSU request); data_rdata_o (registered load word); err_o/err_addr_o (sticky
// first fault); halt_o/tohost_o (TOHOST status). MMIO window enabled by MIRISCV_DMEM_MMIO_EN.
module miriscv_data_mem
  import miriscv_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter string       INIT_FILE   = ""
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            data_req_i,
  input  logic            data_we_i,
  input  logic [BE_W-1:0] data_be_i,
  input  logic [31:0]     data_addr_i,
  input  logic [31:0]     data_wdata_i,
  output logic [31:0]     data_rdata_o,
  output logic            err_o,
  output logic [31:0]     err_addr_o,
  output logic            halt_o,
  output logic [31:0]     tohost_o
);
  localparam int AW = $clog2(DEPTH_WORDS);
  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [31:0]   rdata_q, err_addr_q, mmio_rdata;
  logic          err_q, mmio_sel_q, ram_hit, mmio_hit, fault, ld;
  logic [29:0]   woff;
  logic [AW-1:0] idx;
  always_comb begin
    woff = data_addr_i[31:2] - BASE_ADDR[31:2];
    idx = woff[AW-1:0];
    // offset test instead of an end-address compare so a window ending at 2^32 cannot wrap
    ram_hit = data_addr_i[31:2] >= BASE_ADDR[31:2] && (woff >> AW) == 30'd0;
`ifdef MIRISCV_DMEM_MMIO_EN
    mmio_hit = data_addr_i[31:4] == MMIO_BASE[31:4];
`else
    mmio_hit = 1'b0;
`endif
    fault = data_req_i && !ram_hit && !mmio_hit;
    ld = data_req_i && !data_we_i;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i && data_req_i && data_we_i && ram_hit)
      mem_q[idx] <= be_merge(mem_q[idx], data_wdata_i, data_be_i);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
      mmio_sel_q <= 1'b0;
      err_q <= 1'b0;
      err_addr_q <= '0;
    end else begin
      if (ld) rdata_q <= ram_hit ? mem_q[idx] : FAULT_WORD;
      if (ld) mmio_sel_q <= mmio_hit;
      if (fault) err_q <= 1'b1;
      if (fault && !err_q) err_addr_q <= data_addr_i;
    end
  end
`ifdef MIRISCV_DMEM_MMIO_EN
  miriscv_dmem_mmio u_mmio (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (data_req_i && mmio_hit),
    .we_i    (data_we_i),
    .be_i    (data_be_i),
    .off_i   (data_addr_i[3:2]),
    .wdata_i (data_wdata_i),
    .rdata_o (mmio_rdata),
    .halt_o  (halt_o),
    .tohost_o(tohost_o)
  );
`else
  assign mmio_rdata = '0;
  assign halt_o = 1'b0;
  assign tohost_o = '0;
`endif
  assign data_rdata_o = mmio_sel_q ? mmio_rdata : rdata_q;
  assign err_o = err_q;
  assign err_addr_o = err_addr_q;
endmodule

// File: tb/tb_miriscv_data_mem.sv
// tb_miriscv_data_mem: table-driven self-checking bench for miriscv_data_mem
module tb_miriscv_data_mem;
  logic        clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata, err_addr, tohost;
  logic        err, halt;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t tbl[$];
  miriscv_data_mem dut (
    .clk_i(clk), .rst_i(rst), .data_req_i(req), .data_we_i(we), .data_be_i(be),
    .data_addr_i(addr), .data_wdata_i(wdata), .data_rdata_o(rdata), .err_o(err),
    .err_addr_o(err_addr), .halt_o(halt), .tohost_o(tohost)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic step(input logic r, input logic q, input logic w, input logic [3:0] b,
                      input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    rst = r; req = q; we = w; be = b; addr = a; wdata = d;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    tbl.push_back('{1, 1, 4'hF, 32'h10,  32'h1122_3344, 32'h0,         0});
    tbl.push_back('{1, 0, 4'h0, 32'h10,  32'h0,         32'h1122_3344, 0});
    tbl.push_back('{1, 1, 4'h5, 32'h10,  32'hAABB_CCDD, 32'h1122_3344, 0});
    tbl.push_back('{1, 0, 4'h0, 32'h10,  32'h0,         32'h11BB_33DD, 0});
    tbl.push_back('{1, 1, 4'h0, 32'h10,  32'hFFFF_FFFF, 32'h11BB_33DD, 0});
    tbl.push_back('{1, 0, 4'h0, 32'h13,  32'h0,         32'h11BB_33DD, 0});
    tbl.push_back('{0, 1, 4'hF, 32'h10,  32'h0,         32'h11BB_33DD, 0});
    tbl.push_back('{0, 0, 4'hF, 32'h14,  32'h0,         32'h11BB_33DD, 0});
    tbl.push_back('{0, 1, 4'hF, 32'h10,  32'h0,         32'h11BB_33DD, 0});
    tbl.push_back('{1, 1, 4'hF, 32'h14,  32'h1234_5678, 32'h11BB_33DD, 0});
    tbl.push_back('{1, 0, 4'h0, 32'h14,  32'h0,         32'h1234_5678, 0});
    tbl.push_back('{1, 1, 4'hF, 32'hFFC, 32'hCAFE_F00D, 32'h1234_5678, 0});
    tbl.push_back('{1, 0, 4'h0, 32'hFFC, 32'h0,         32'hCAFE_F00D, 0});
    tbl.push_back('{1, 1, 4'hF, 32'h0,   32'h0102_0304, 32'hCAFE_F00D, 0});
    tbl.push_back('{1, 0, 4'h0, 32'h1000, 32'h0,        32'hDEAD_BEEF, 1});
    tbl.push_back('{1, 0, 4'h0, 32'h4000_0000, 32'h0,   32'hDEAD_BEEF, 1});
    tbl.push_back('{1, 1, 4'hF, 32'h1000, 32'h9999_9999, 32'hDEAD_BEEF, 1});
    tbl.push_back('{1, 0, 4'h0, 32'h0,   32'h0,         32'h0102_0304, 1});
    step(1, 0, 0, 4'h0, 32'h0, 32'h0);
    step(1, 1, 1, 4'hF, 32'h1000, 32'h0);
    chk("reset rdata", rdata, 32'h0);
    chk("reset err", {31'd0, err}, 32'd0);
    chk("reset err_addr", err_addr, 32'h0);
    chk("reset halt", {31'd0, halt}, 32'd0);
    chk("reset tohost", tohost, 32'h0);
    for (int i = 0; i < tbl.size(); i++) begin
      step(0, tbl[i].req, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata);
      chk($sformatf("vec%0d rdata", i), rdata, tbl[i].exp_rdata);
      chk($sformatf("vec%0d err", i), {31'd0, err}, {31'd0, tbl[i].exp_err});
    end
    chk("first fault addr", err_addr, 32'h1000);
    step(1, 1, 1, 4'hF, 32'h14, 32'h5555_5555);
    chk("rst+store rdata", rdata, 32'h0);
    chk("rst+store err", {31'd0, err}, 32'd0);
    chk("rst+store err_addr", err_addr, 32'h0);
    step(0, 1, 0, 4'h0, 32'h14, 32'h0);
    chk("store in reset dropped", rdata, 32'h1234_5678);
    step(0, 1, 0, 4'h0, 32'h10, 32'h0);
    chk("ram kept over reset", rdata, 32'h11BB_33DD);
`ifdef MIRISCV_DMEM_MMIO_EN
    step(1, 0, 0, 4'h0, 32'h0, 32'h0);
    repeat (5) step(0, 0, 0, 4'h0, 32'h0, 32'h0);
    step(0, 1, 0, 4'h0, 32'h8000_0000, 32'h0);
    chk("cycle_lo at 5", rdata, 32'd5);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h8000_0000;
    force dut.u_mmio.cycle_q = 64'h0000_0000_FFFF_FFFF;
    #1 release dut.u_mmio.cycle_q;
    @(posedge clk);
    #1;
    chk("cycle_lo forced", rdata, 32'hFFFF_FFFF);
    step(0, 1, 0, 4'h0, 32'h8000_0004, 32'h0);
    chk("cycle_hi shadow", rdata, 32'h0);
    step(0, 1, 0, 4'h0, 32'h8000_0000, 32'h0);
    chk("cycle_lo after carry", rdata, 32'h1);
    step(0, 1, 0, 4'h0, 32'h8000_0004, 32'h0);
    chk("cycle_hi after carry", rdata, 32'h1);
    step(0, 1, 1, 4'hF, 32'h8000_0008, 32'h1);
    chk("halt set", {31'd0, halt}, 32'd1);
    chk("tohost value", tohost, 32'h1);
    step(0, 1, 1, 4'hF, 32'h8000_0000, 32'h0);
    chk("cycle store not fault", {31'd0, err}, 32'd0);
    step(0, 1, 1, 4'h3, 32'h8000_000C, 32'hABCD_1234);
    step(0, 1, 0, 4'h0, 32'h8000_000C, 32'h0);
    chk("scratch be merge", rdata, 32'h0000_1234);
    step(1, 1, 1, 4'hF, 32'h8000_000C, 32'h5);
    chk("rst halt", {31'd0, halt}, 32'd0);
    chk("rst tohost", tohost, 32'h0);
    chk("rst mmio rdata", rdata, 32'h0);
    step(0, 1, 0, 4'h0, 32'h8000_000C, 32'h0);
    chk("scratch reset", rdata, 32'h0);
    step(0, 1, 0, 4'h0, 32'h10, 32'h0);
    chk("ram after mmio reset", rdata, 32'h11BB_33DD);
`else
    step(0, 1, 1, 4'hF, 32'h8000_0008, 32'h1);
    chk("mmio off halt", {31'd0, halt}, 32'd0);
    chk("mmio off tohost", tohost, 32'h0);
    chk("mmio off fault", {31'd0, err}, 32'd1);
    chk("mmio off err_addr", err_addr, 32'h8000_0008);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
